// File: rtl/out_display_ctrl_pkg.sv
// Shared constants for the OUT-instruction display controller: slot/digit geometry and
// the hex-to-7-segment table (active-high, bit0 = segment a).
package out_display_ctrl_pkg;

  localparam int NUM_SLOTS  = 4;
  localparam int NUM_DIGITS = 8;
  localparam int SLOT_W     = 16;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G - SEG_A + 1;

  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [NUM_DIGITS-1:0] digit_enable_n(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/out_display_ctrl_seg7_hex_decoder.sv
// Combinational nibble to active-high 7-segment pattern.
module seg7_hex_decoder
  import out_display_ctrl_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  logic [SEG_W-1:0] pat;

  always_comb begin
    pat = HEX_SEG[nibble_i];
    seg_o = '0;
    seg_o[SEG_A] = pat[0];
    seg_o[SEG_B] = pat[1];
    seg_o[SEG_C] = pat[2];
    seg_o[SEG_D] = pat[3];
    seg_o[SEG_E] = pat[4];
    seg_o[SEG_F] = pat[5];
    seg_o[SEG_G] = pat[6];
  end

endmodule

// File: rtl/out_display_ctrl.sv
// Captures processor OUT results into four slots and scans them onto an 8-digit
// multiplexed hex display; decimal points flag fresh writes, display blinks while halting.
module out_display_ctrl
  import out_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV    = 1024,
  parameter int BLINK_DIV   = 256,
  parameter int FRESH_TICKS = 2048
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        outdisplay,
  input  logic [2:0]  outsel,
  input  logic [15:0] outval1,
  input  logic [15:0] outval2,
  input  logic        halting,
  input  logic        page,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n,
  output logic [15:0] out_count
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int FW = $clog2(FRESH_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [FW-1:0] FRESH_LOAD = FW'(FRESH_TICKS);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_nxt;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_ph_q, blink_ph_d;
  logic [SLOT_W-1:0]     slot_q [NUM_SLOTS];
  logic [SLOT_W-1:0]     slot_d [NUM_SLOTS];
  logic [FW-1:0]         fresh_q [NUM_SLOTS];
  logic [FW-1:0]         fresh_d [NUM_SLOTS];
  logic [SEG_W-1:0]      seg_q, seg_d, seg_pat;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0]  wr_en;
  logic [1:0]            sel_slot;
  logic [3:0]            nibble;
  logic                  tick;

  assign tick = (presc_q == PRESC_LAST);

  // Capture bank and fresh timers; a reload on the same edge as a tick beats the decrement.
  always_comb begin
    wr_en = '0;
    if (outdisplay) begin
      if (outsel[2]) begin
        wr_en[{outsel[1], 1'b0}] = 1'b1;
        wr_en[{outsel[1], 1'b1}] = 1'b1;
      end else begin
        wr_en[outsel[1:0]] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_d[i]  = slot_q[i];
      fresh_d[i] = fresh_q[i];
      if (tick && (fresh_q[i] != '0)) fresh_d[i] = fresh_q[i] - 1'b1;
      if (wr_en[i]) begin
        slot_d[i]  = (outsel[2] && (i % 2 == 1)) ? outval2 : outval1;
        fresh_d[i] = FRESH_LOAD;
      end
    end
    cnt_d = cnt_q;
    if (outdisplay && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // The tick edge loads outputs for the digit being stepped to, from pre-edge slot values.
  always_comb begin
    idx_nxt  = idx_q + 1'b1;
    sel_slot = {page, idx_nxt[IDX_W-1]};
    nibble   = slot_q[sel_slot][{idx_nxt[1:0], 2'b00} +: 4];
  end

  seg7_hex_decoder u_dec (
    .nibble_i (nibble),
    .seg_o    (seg_pat)
  );

  always_comb begin
    presc_d     = tick ? '0 : presc_q + 1'b1;
    idx_d       = idx_q;
    seg_d       = seg_q;
    dp_d        = dp_q;
    an_d        = an_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (!halting) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    if (tick) begin
      idx_d = idx_nxt;
      seg_d = ~seg_pat;
      dp_d  = ~((idx_nxt[1:0] == 2'b00) && (fresh_q[sel_slot] != '0));
      an_d  = (halting && blink_ph_q) ? '1 : digit_enable_n(idx_nxt);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      an_q        <= '1;
      cnt_q       <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i]  <= '0;
        fresh_q[i] <= '0;
      end
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      fresh_q     <= fresh_d;
    end
  end

  assign seg_n     = seg_q;
  assign dp_n      = dp_q;
  assign an_n      = an_q;
  assign out_count = cnt_q;

endmodule
